riscv_fetch_unit: RTL and testbench
===================================

// Module: riscv_fetch_unit
// PURPOSE
//  Instruction-fetch front end for the 5-stage RISC-V pipeline; produces the IF/ID instruction stream.
//  Owns the PC and issues word requests to a variable-latency instruction memory.
//  Buffers returned words in a small prefetch FIFO and hands {instr,pc} to decode with valid/ready.
//  Accepts branch/jump redirects from EX, flushing buffered and in-flight fetches.
// PARAMETERS
//  XLEN        64      PC / address width
//  FIFO_DEPTH  4       prefetch entries, power of 2, >=2
//  RESET_PC    64'h0   PC after reset
// PORTS
//  clock          in   1     single clock, all state on posedge
//  reset          in   1     asynchronous, active-high
//  redirect_valid in   1     EX resolved taken branch/jump this cycle
//  redirect_pc    in   XLEN  new fetch PC, bits[1:0] ignored (forced 0)
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     imem accepts request
//  imem_req_addr  out  XLEN  byte address, always 4-aligned
//  imem_rsp_valid in   1     response valid; in order; >=1 cycle after accept
//  imem_rsp_data  in   32    instruction word
//  dec_valid      out  1     instruction available to decode
//  dec_ready      in   1     decode accepts (stall when 0)
//  dec_instr      out  32    instruction; NOP 32'h0000_0013 when dec_valid=0
//  dec_pc         out  XLEN  PC of dec_instr
// BEHAVIOUR
//  Reset: PC=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, imem_req_valid=0, dec_valid=0, dec_instr=NOP.
//  Issue: imem_req_valid = !reset_q && !redirect_valid && (inflight + fifo_count < FIFO_DEPTH).
//   imem_req_addr = PC. On req accept (valid&&ready): PC<=PC+4 (wraps mod 2^XLEN), inflight++.
//  Response: rsp decrements inflight. If drop_cnt>0: word discarded, drop_cnt--. Else pushed
//   with its PC (rsp PC tracked by a second counter rsp_pc, +4 per kept response).
//  Credit rule guarantees a kept response never finds the FIFO full; push into full FIFO is an assertion failure.
//  Decode: dec_valid = fifo_nonempty && !redirect_valid; pop when dec_valid&&dec_ready. Head is
//   combinational from storage (0-cycle). Min latency req accept -> dec_valid = imem latency + 1 cycle.
//  Simultaneous push+pop on a non-empty FIFO: count unchanged. Push into empty FIFO: visible next cycle.
//  Redirect (priority over all else in that cycle): FIFO cleared; PC<=rsp_pc<={redirect_pc[XLEN-1:2],2'b00};
//   drop_cnt <= inflight_next (all in-flight incl. one accepted/returning this cycle are stale);
//   no request issued, no pop in redirect cycle. First new request next cycle.
//  Back-to-back redirects: each recomputes drop_cnt from current inflight; last one wins.
//  reset asserted mid-operation: all state returns to reset values asynchronously; stale imem
//   responses after reset are the memory's responsibility (imem is reset on the same reset).
//  dec_ready=0 for long periods: requests stop once inflight+count==FIFO_DEPTH; no data lost.
// CONFIGURATION
//  RISCV_FETCH_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles dec_valid&&!dec_ready)
//   and perf_empty_cnt[31:0] (cycles !dec_valid && !reset), both reset 0, saturate at 32'hFFFF_FFFF;
//   perf_flush_cnt[15:0] counts redirects, wraps.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package riscv_pkg: XLEN, NOP_INSTR=32'h0000_0013, opcode constants LD/SD/BEQ/ALUOP, fetch_entry_t {instr,pc}.
//  Sub-module riscv_fetch_fifo (DEPTH, entry width; push/pop/flush/count/head) instantiated once;
//   PC, credit and drop logic live in riscv_fetch_unit.
// TESTING
//  1 Reset, imem 1-cycle latency, dec_ready=1: requests at 0,4,8..; dec_pc 0,4,8 one per cycle after fill.
//  2 dec_ready=0 from cycle 3: exactly 4 requests total outstanding+buffered; release -> PCs 0..C in order, none lost.
//  3 Redirect to 0x100 with 2 in flight (3-cycle imem): both stale rsps dropped; next dec_pc=0x100, then 0x104.
//  4 Redirect same cycle as rsp and dec handshake: no pop, rsp dropped, FIFO empty next cycle, req addr=0x100.
//  5 redirect_pc=0x203: req addr 0x200; PC=64'hFFFF_FFFF_FFFF_FFFC fetches then wraps to 0.
//  6 Assert reset while FIFO holds 3 entries: dec_valid=0, dec_instr=NOP immediately; first req addr=RESET_PC.
//  PERF build: 5 stall cycles -> perf_stall_cnt=5; 2 redirects -> perf_flush_cnt=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V fetch front end: word width constants,
// the canonical NOP, a few base opcodes and the IF/ID entry layout.
package riscv_pkg;

  localparam int XLEN = 64;

  // addi x0, x0, 0 -- what decode sees whenever no instruction is presented
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes (instr[6:0]) used by downstream stages
  localparam logic [6:0] OPC_LD    = 7'b000_0011;
  localparam logic [6:0] OPC_SD    = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ   = 7'b110_0011;
  localparam logic [6:0] OPC_ALUOP = 7'b011_0011;

  // One IF/ID hand-off: the instruction word and the PC it was fetched from
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_checker.sv
// Protocol assertions for the fetch unit: a kept response must never meet a
// full prefetch FIFO, and issued fetch addresses are always word aligned.
module riscv_fetch_checker (
  input logic       clock_i,
  input logic       reset_i,
  input logic       push_i,
  input logic       full_i,
  input logic       req_valid_i,
  input logic [1:0] req_addr_lo_i
);

  a_push_not_full: assert property (@(posedge clock_i) disable iff (reset_i)
    push_i |-> !full_i)
    else $error("fetch fifo overflow: kept response arrived with fifo full");

  a_req_aligned: assert property (@(posedge clock_i) disable iff (reset_i)
    req_valid_i |-> (req_addr_lo_i == 2'b00))
    else $error("fetch request address not word aligned");

endmodule

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO for the fetch unit. DEPTH must be a power of two (>=2) so the
// read/write pointers wrap naturally. Flush has priority over push and pop.
// The head entry is read straight from storage, so a word pushed into an
// empty FIFO becomes visible on the following cycle.
module riscv_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_FULL);
  assign do_push_s = push_i && !full_o && !flush_i;
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next pointers and occupancy; a flush empties the FIFO regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy state with asynchronous reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clock_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests to a
// variable-latency in-order instruction memory, buffers returned words in a
// prefetch FIFO and presents {instr, pc} to decode with valid/ready.
// A redirect from EX flushes the FIFO and marks every in-flight request stale.
// Optional feature macro: RISCV_FETCH_PERF_EN adds perf_stall_cnt,
// perf_empty_cnt and perf_flush_cnt outputs.
module riscv_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc
`ifdef RISCV_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_empty_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 32 + XLEN;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            reset_q;

  logic [CW-1:0]   inflight_next_s;
  logic [CW-1:0]   fifo_count_s;
  logic [CW:0]     credit_used_s;
  logic            req_fire_s;
  logic            keep_rsp_s;
  logic            pop_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic [EW-1:0]   fifo_head_s;
  logic [XLEN-1:0] redir_pc_s;

  // Requests in flight plus words buffered may never exceed the FIFO size,
  // which is what guarantees every kept response a free slot.
  assign credit_used_s  = {1'b0, inflight_q} + {1'b0, fifo_count_s};
  assign imem_req_valid = !reset_q && !redirect_valid && (credit_used_s < CREDIT_MAX);
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign redir_pc_s     = redirect_pc & ALIGN_MASK;

  // A response is stale while drop_cnt is non-zero, and anything arriving in
  // a redirect cycle is counted into the new drop_cnt instead of being kept.
  assign keep_rsp_s = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

  assign dec_valid = !fifo_empty_s && !redirect_valid;
  assign pop_s     = dec_valid && dec_ready;
  assign dec_instr = dec_valid ? fifo_head_s[EW-1:XLEN] : NOP_INSTR;
  assign dec_pc    = dec_valid ? fifo_head_s[XLEN-1:0]  : '0;

  // Outstanding-request count after this cycle's accept and response.
  always_comb begin
    case ({req_fire_s, imem_rsp_valid})
      2'b10:   inflight_next_s = inflight_q + CNT_ONE;
      2'b01:   inflight_next_s = inflight_q - CNT_ONE;
      default: inflight_next_s = inflight_q;
    endcase
  end

  // PC, response-PC and stale-drop bookkeeping; a redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_next_s;
    if (redirect_valid) begin
      pc_d       = redir_pc_s;
      rsp_pc_d   = redir_pc_s;
      drop_cnt_d = inflight_next_s;
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CNT_ONE;
      end else if (keep_rsp_s) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Fetch state registers; reset_q holds off requests for the first cycle out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      reset_q    <= 1'b1;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      reset_q    <= 1'b0;
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clock_i     (clock),
    .reset_i     (reset),
    .push_i      (keep_rsp_s),
    .push_data_i ({imem_rsp_data, rsp_pc_q}),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head_s),
    .count_o     (fifo_count_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s)
  );

  riscv_fetch_checker u_checker (
    .clock_i       (clock),
    .reset_i       (reset),
    .push_i        (keep_rsp_s),
    .full_i        (fifo_full_s),
    .req_valid_i   (imem_req_valid),
    .req_addr_lo_i (imem_req_addr[1:0])
  );

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] empty_cnt_q;
  logic [15:0] flush_cnt_q;

  // Performance counters: stall/empty saturate, redirect count wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'h0000_0000;
      empty_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (dec_valid && !dec_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!dec_valid && (empty_cnt_q != 32'hFFFF_FFFF)) begin
        empty_cnt_q <= empty_cnt_q + 32'd1;
      end else begin
        empty_cnt_q <= empty_cnt_q;
      end
      if (redirect_valid) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_empty_cnt = empty_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit. The driver models an in-order
// variable-latency instruction memory and, whenever the fetch stream is
// (re)started by reset or redirect, pushes the expected sequential
// {instr, pc} stream into a queue. A separate monitor pops that queue on
// every decode handshake and checks the presentation rules each cycle.
module tb_riscv_fetch_unit;
  import riscv_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_empty_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  riscv_fetch_unit #(
    .XLEN       (64),
    .FIFO_DEPTH (4),
    .RESET_PC   (RST_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef RISCV_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_empty_cnt (perf_empty_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];
  logic [63:0]  exp_next_pc;
  logic [63:0]  exp_req_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due = 0;
  int accepts = 0;
  int hs = 0;
  int stall_exp = 0;
  int empty_exp = 0;
  int flush_exp = 0;
  int ready_pct, dec_pct, redir_pct, min_lat, max_lat;

  // Memory contents: every address holds a distinct, address-derived word.
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F17;
  endfunction

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{instr: imem_word(exp_next_pc), pc: exp_next_pc});
      exp_next_pc = exp_next_pc + 64'd4;
    end
  endtask

  task automatic restart_stream(input logic [63:0] start_pc);
    exp_q.delete();
    exp_next_pc  = start_pc;
    exp_req_addr = start_pc;
    top_up();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    pend_q.delete();
    accepts   = 0;
    stall_exp = 0;
    empty_exp = 0;
    flush_exp = 0;
    last_due  = cyc;
    restart_stream(RST_PC);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // One bus cycle: drive inputs at the negedge, then record what the
  // following posedge will accept.
  task automatic step(input bit force_redir, input logic [63:0] rpc);
    int lat;
    int due;
    bit redir;
    @(negedge clock);
    cyc++;
    redir = force_redir || ($urandom_range(99) < redir_pct);
    redirect_valid = redir;
    if (force_redir) redirect_pc = rpc;
    else if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
    else redirect_pc = {32'h0000_0000, $urandom};
    imem_req_ready = ($urandom_range(99) < ready_pct);
    dec_ready      = ($urandom_range(99) < dec_pct);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = imem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (redir) begin
      flush_exp++;
      restart_stream(redirect_pc & ~64'd3);
    end else begin
      top_up();
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      checks++;
      if (imem_req_addr !== exp_req_addr) begin
        errors++;
        $display("FAIL req_addr cycle %0d: got %h expected %h", cyc, imem_req_addr, exp_req_addr);
      end
      exp_req_addr = exp_req_addr + 64'd4;
      accepts++;
      lat = $urandom_range(max_lat, min_lat);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_q.push_back('{addr: imem_req_addr, due: due});
      last_due = due;
    end
  endtask

  // Monitor: decode handshakes against the scoreboard, plus per-cycle rules.
  always @(negedge clock) begin
    fetch_entry_t e;
    #2;
    if (dec_valid) begin
      if (dec_ready) begin
        hs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dec_stream: handshake pc %h with empty scoreboard", dec_pc);
        end else begin
          e = exp_q.pop_front();
          if (dec_pc !== e.pc || dec_instr !== e.instr) begin
            errors++;
            $display("FAIL dec_stream: got pc %h instr %h expected pc %h instr %h",
                     dec_pc, dec_instr, e.pc, e.instr);
          end
        end
      end else if (!reset) begin
        stall_exp++;
      end
    end else begin
      if (!reset) empty_exp++;
      checks++;
      if (dec_instr !== NOP_INSTR) begin
        errors++;
        $display("FAIL idle_nop: got instr %h expected %h", dec_instr, NOP_INSTR);
      end
    end
    if (reset || redirect_valid) begin
      checks++;
      if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL quiet_cycle: got dec_valid %b req_valid %b expected 0 0",
                 dec_valid, imem_req_valid);
      end
    end
  end

  initial begin
    int hs_mark;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    dec_ready      = 1'b0;
    ready_pct = 100; dec_pct = 100; redir_pct = 0; min_lat = 1; max_lat = 1;
    restart_stream(RST_PC);
    do_reset();

    // Decode stalled from the start: exactly FIFO_DEPTH requests may issue.
    dec_pct = 0;
    repeat (30) step(1'b0, 64'h0);
    checks++;
    if (accepts != 4) begin
      errors++;
      $display("FAIL credit_limit: got %0d requests expected 4", accepts);
    end

    // Reset with a full FIFO, then stream at 1-cycle latency.
    do_reset();
    dec_pct = 100;
    hs_mark = hs;
    repeat (40) step(1'b0, 64'h0);
    checks++;
    if (hs - hs_mark < 35) begin
      errors++;
      $display("FAIL throughput: got %0d handshakes expected at least 35", hs - hs_mark);
    end

    // 3-cycle memory with directed redirects: stale drop, misalignment, wrap.
    min_lat = 3; max_lat = 3;
    repeat (10) step(1'b0, 64'h0);
    step(1'b1, 64'h100);
    repeat (20) step(1'b0, 64'h0);
    step(1'b1, 64'h203);
    repeat (20) step(1'b0, 64'h0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (20) step(1'b0, 64'h0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
    step(1'b1, 64'h40);
    repeat (20) step(1'b0, 64'h0);

    // Randomized traffic with a reset in the middle.
    min_lat = 1; max_lat = 4; ready_pct = 70; dec_pct = 60; redir_pct = 5;
    hs_mark = hs;
    repeat (1500) step(1'b0, 64'h0);
    do_reset();
    repeat (1500) step(1'b0, 64'h0);
    checks++;
    if (hs - hs_mark < 300) begin
      errors++;
      $display("FAIL progress: got %0d handshakes expected at least 300", hs - hs_mark);
    end

`ifdef RISCV_FETCH_PERF_EN
    redir_pct = 0;
    step(1'b0, 64'h0);
    @(posedge clock);
    #1;
    checks++;
    if (perf_stall_cnt !== 32'(stall_exp)) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, stall_exp);
    end
    checks++;
    if (perf_empty_cnt !== 32'(empty_exp)) begin
      errors++;
      $display("FAIL perf_empty: got %0d expected %0d", perf_empty_cnt, empty_exp);
    end
    checks++;
    if (perf_flush_cnt !== 16'(flush_exp)) begin
      errors++;
      $display("FAIL perf_flush: got %0d expected %0d", perf_flush_cnt, flush_exp);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
